// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch front end with PC-tagged prefetch FIFO
module ifetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   output logic        imem_en,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

   logic [31:0]   fpc_q, fpc_d;
   logic          inflight_q, inflight_d;
   logic [31:0]   req_pc_q, req_pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [31:0]   pc_mem_q   [DEPTH];
   logic [31:0]   word_mem_q [DEPTH];

   logic          push;
   logic          pop;
   logic [CW:0]   credit_used;

   // Credit counts the outstanding read so a returning word always has a free slot.
   assign credit_used = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
   assign imem_en     = reset & ~redirect & (credit_used < (CW+1)'(DEPTH));
   assign imem_addr   = reset ? fpc_q : RESET_PC_AL;

   assign inst_valid  = reset & (count_q != '0);
   assign inst        = inst_valid ? word_mem_q[rd_ptr_q] : 32'h0;
   assign inst_pc     = inst_valid ? pc_mem_q[rd_ptr_q]   : 32'h0;

   assign push = inflight_q & ~redirect;
   assign pop  = inst_valid & inst_ready;

   always_comb begin
      fpc_d      = fpc_q;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      inflight_d = imem_en;
      req_pc_d   = fpc_q;
      if (redirect) begin
         fpc_d    = {redirect_pc[31:2], 2'b00};
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         if (imem_en) fpc_d = fpc_q + 32'd4;
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         fpc_q      <= RESET_PC_AL;
         inflight_q <= 1'b0;
         req_pc_q   <= RESET_PC_AL;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         fpc_q      <= fpc_d;
         inflight_q <= inflight_d;
         req_pc_q   <= req_pc_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   // Entry storage needs no reset: inst_valid masks anything not yet written.
   always_ff @(posedge clk) begin
      if (reset && push) begin
         pc_mem_q[wr_ptr_q]   <= req_pc_q;
         word_mem_q[wr_ptr_q] <= imem_rdata;
      end
   end

   no_overflow_a: assert property (@(posedge clk) disable iff (!reset)
      !(push && count_q == CW'(DEPTH)));

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - directed bench with queue-based reference model for ifetch_queue
module tb_ifetch_queue;

   localparam int DEPTH = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        reset;
   logic [31:0] imem_addr;
   logic        imem_en;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 0;

   logic [31:0] m_q[$];
   logic [31:0] m_fpc;
   logic [31:0] m_req_pc;
   int          m_infl;
   logic [63:0] acc_log[$];

   ifetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_addr   (imem_addr),
      .imem_en     (imem_en),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .inst_valid  (inst_valid),
      .inst        (inst),
      .inst_pc     (inst_pc),
      .inst_ready  (inst_ready)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rom(input logic [31:0] a);
      return 32'h1000_0000 + (a >> 2);
   endfunction

   // Block RAM with one-cycle read latency
   initial imem_rdata = 32'h0;
   always @(posedge clk) begin
      if (imem_en) imem_rdata <= rom(imem_addr);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_log(input int i, input logic [31:0] pc, input logic [31:0] word);
      if (acc_log.size() > i) begin
         chk($sformatf("log[%0d].pc", i), acc_log[i][63:32], pc);
         chk($sformatf("log[%0d].inst", i), acc_log[i][31:0], word);
      end else begin
         chk($sformatf("log[%0d] present", i), acc_log.size(), i + 1);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: queue of delivered PCs, one outstanding read, credit-limited issue.
   logic exp_en;
   logic exp_valid;
   always @(negedge clk) begin
      exp_en    = reset && !redirect && ((m_q.size() + m_infl) < DEPTH);
      exp_valid = reset && (m_q.size() != 0);
      if (chk_en) begin
         chk("imem_en", imem_en, exp_en);
         chk("imem_addr", imem_addr, reset ? m_fpc : RESET_PC);
         chk("inst_valid", inst_valid, exp_valid);
         if (exp_valid) begin
            chk("inst_pc", inst_pc, m_q[0]);
            chk("inst", inst, rom(m_q[0]));
         end
         if (inst_valid && inst_ready) acc_log.push_back({inst_pc, inst});
      end
      if (!reset) begin
         m_q.delete();
         m_fpc  = RESET_PC;
         m_infl = 0;
      end else if (redirect) begin
         m_q.delete();
         m_fpc  = {redirect_pc[31:2], 2'b00};
         m_infl = 0;
      end else begin
         if (exp_valid && inst_ready) void'(m_q.pop_front());
         if (m_infl != 0) m_q.push_back(m_req_pc);
         m_infl   = exp_en ? 1 : 0;
         m_req_pc = m_fpc;
         if (exp_en) m_fpc = m_fpc + 32'd4;
      end
   end

   initial begin
      reset = 0; redirect = 0; redirect_pc = 0; inst_ready = 1;
      m_q.delete(); m_fpc = RESET_PC; m_infl = 0; m_req_pc = RESET_PC;
      repeat (3) tick();
      chk_en = 1;
      #1;
      chk("rst valid", inst_valid, 0);
      chk("rst en", imem_en, 0);
      chk("rst addr", imem_addr, 32'h0);

      // 1: streaming from reset
      reset = 1; #1;
      chk("t1 c0 en", imem_en, 1);
      chk("t1 c0 valid", inst_valid, 0);
      tick(); chk("t1 c1 valid", inst_valid, 0);
      tick(); chk("t1 c2 valid", inst_valid, 1);
      chk("t1 c2 pc", inst_pc, 32'h0);
      acc_log.delete();
      repeat (8) tick();
      chk("t1 log size", acc_log.size(), 8);
      for (int i = 0; i < 6; i++) chk_log(i, 32'(4 * i), 32'h1000_0000 + 32'(i));

      // 2: backpressure fills the FIFO
      reset = 0; tick();
      reset = 1; inst_ready = 0;
      repeat (8) tick();
      chk("t2 en stalled", imem_en, 0);
      chk("t2 valid", inst_valid, 1);
      chk("t2 head pc", inst_pc, 32'h0);
      acc_log.delete();
      inst_ready = 1;
      repeat (10) tick();
      for (int i = 0; i < 6; i++) chk_log(i, 32'(4 * i), 32'h1000_0000 + 32'(i));

      // 3: redirect while streaming, low bits of target ignored
      redirect = 1; redirect_pc = 32'h0000_0043;
      tick();
      redirect = 0; #1;
      chk("t3 r1 en", imem_en, 1);
      chk("t3 r1 addr", imem_addr, 32'h40);
      chk("t3 r1 valid", inst_valid, 0);
      tick(); chk("t3 r2 valid", inst_valid, 0);
      tick(); chk("t3 r3 valid", inst_valid, 1);
      chk("t3 r3 pc", inst_pc, 32'h40);
      chk("t3 r3 inst", inst, 32'h1000_0010);
      inst_ready = 0;

      // 4: full FIFO, pop and redirect in the same cycle
      repeat (6) tick();
      chk("t4 full en", imem_en, 0);
      chk("t4 full pc", inst_pc, 32'h40);
      acc_log.delete();
      inst_ready = 1; redirect = 1; redirect_pc = 32'h100;
      tick();
      redirect = 0; #1;
      chk("t4 popped once", acc_log.size(), 1);
      chk_log(0, 32'h40, 32'h1000_0010);
      chk("t4 r1 valid", inst_valid, 0);
      tick(); chk("t4 r2 valid", inst_valid, 0);
      tick(); chk("t4 r3 pc", inst_pc, 32'h100);
      chk("t4 r3 inst", inst, 32'h1000_0040);
      chk("t4 no stale", acc_log.size(), 1);

      // 5: one-cycle reset mid-stream drops in-flight read
      repeat (5) tick();
      reset = 0; #1;
      chk("t5 x en", imem_en, 0);
      chk("t5 x valid", inst_valid, 0);
      chk("t5 x addr", imem_addr, RESET_PC);
      tick();
      reset = 1; #1;
      chk("t5 x1 valid", inst_valid, 0);
      chk("t5 x1 addr", imem_addr, RESET_PC);
      acc_log.delete();
      repeat (6) tick();
      chk_log(0, 32'h0, 32'h1000_0000);
      chk_log(1, 32'h4, 32'h1000_0001);

      // irregular ready pattern exercises simultaneous push/pop
      for (int i = 0; i < 24; i++) begin
         inst_ready = (i % 3) != 0;
         tick();
      end
      inst_ready = 1;

      // back-to-back redirects: last one wins
      redirect = 1; redirect_pc = 32'h200; tick();
      redirect_pc = 32'h300; tick();
      redirect = 0;
      acc_log.delete();
      repeat (5) tick();
      chk_log(0, 32'h300, 32'h1000_00C0);

      // 6: fetch PC wraps at the top of the address space
      redirect = 1; redirect_pc = 32'hFFFF_FFFC; tick();
      redirect = 0;
      acc_log.delete();
      repeat (6) tick();
      chk_log(0, 32'hFFFF_FFFC, 32'h4FFF_FFFF);
      chk_log(1, 32'h0000_0000, 32'h1000_0000);
      chk_log(2, 32'h0000_0004, 32'h1000_0001);

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
